// File: rtl/rom_bus_controller.sv
// rtl/rom_bus_controller.sv - memory-side sequencer for the 4-bit multiplexed instruction bus
module rom_bus_controller #(
  parameter logic [3:0] ROM_BANK = 4'h0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sync,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [2:0] phase,
  output logic       locked,
  output logic       selected,
  output logic       sync_err
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  phase_t     phase_q, phase_d;
  logic       locked_q, locked_d;
  // Set for the X3 slot inserted after a (re)lock: the sync that framed it
  // was already consumed, so a missing sync there is not a violation.
  logic       reframe_q, reframe_d;
  logic       selected_q, selected_d;
  logic       sync_err_q, sync_err_d;
  logic [3:0] addr_lo_q;
  logic [3:0] addr_hi_q;
  logic [3:0] opa_q;
  logic       bank_hit;

  assign bank_hit = (data_in == ROM_BANK);

  // Control state register: phase, lock, selection and error pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q    <= PH_X3;
      locked_q   <= 1'b0;
      reframe_q  <= 1'b0;
      selected_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      locked_q   <= locked_d;
      reframe_q  <= reframe_d;
      selected_q <= selected_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Phase sequencing, sync framing checks and bank selection.
  always_comb begin
    phase_d    = phase_q;
    locked_d   = locked_q;
    reframe_d  = reframe_q;
    selected_d = selected_q;
    sync_err_d = 1'b0;
    if (!locked_q) begin
      if (sync) begin
        locked_d  = 1'b1;
        phase_d   = PH_X3;
        reframe_d = 1'b1;
      end
    end else if (sync && (phase_q != PH_X3)) begin
      // Early sync: re-frame and drop whatever fetch was in flight.
      sync_err_d = 1'b1;
      phase_d    = PH_X3;
      reframe_d  = 1'b1;
      selected_d = 1'b0;
    end else if ((phase_q == PH_X3) && !sync && !reframe_q) begin
      // Missing sync: framing lost, wait for the next sync to relock.
      sync_err_d = 1'b1;
      locked_d   = 1'b0;
      selected_d = 1'b0;
      phase_d    = PH_X3;
    end else begin
      phase_d   = phase_t'(phase_q + 3'd1);
      reframe_d = 1'b0;
      if (phase_q == PH_A3) begin
        selected_d = bank_hit;
      end else if (phase_q == PH_X3) begin
        selected_d = 1'b0;
      end
    end
  end

  // Address nibble capture and OPA latch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_lo_q <= 4'h0;
      addr_hi_q <= 4'h0;
      opa_q     <= 4'h0;
    end else if (locked_q) begin
      if (phase_q == PH_A1) begin
        addr_lo_q <= data_in;
      end
      if (phase_q == PH_A2) begin
        addr_hi_q <= data_in;
      end
      if (phase_q == PH_M1) begin
        opa_q <= mem_rdata[3:0];
      end
    end
  end

  // Memory strobe in A3 and bus drive in M1/M2.
  always_comb begin
    mem_rd   = locked_q && (phase_q == PH_A3) && bank_hit;
    mem_addr = {addr_hi_q, addr_lo_q};
    data_oe  = 1'b0;
    data_out = 4'h0;
    if (selected_q && (phase_q == PH_M1)) begin
      data_oe  = 1'b1;
      data_out = mem_rdata[7:4];
    end else if (selected_q && (phase_q == PH_M2)) begin
      data_oe  = 1'b1;
      data_out = opa_q;
    end
  end

  assign phase    = phase_q;
  assign locked   = locked_q;
  assign selected = selected_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_rom_bus_controller.sv
// tb/tb_rom_bus_controller.sv - directed scoreboard bench for rom_bus_controller
module tb_rom_bus_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] data_in = 4'h0;

  logic [3:0] dout [2];
  logic       doe [2];
  logic       mrd [2];
  logic [7:0] maddr [2];
  logic [7:0] mrdata [2];
  logic [2:0] ph [2];
  logic       lck [2];
  logic       sel [2];
  logic       serr [2];

  int checks = 0;
  int errors = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  always #5 clock = ~clock;

  rom_bus_controller #(.ROM_BANK(4'h0)) u0 (
    .clock(clock), .reset(reset), .sync(sync), .data_in(data_in),
    .data_out(dout[0]), .data_oe(doe[0]), .mem_rd(mrd[0]), .mem_addr(maddr[0]),
    .mem_rdata(mrdata[0]), .phase(ph[0]), .locked(lck[0]), .selected(sel[0]),
    .sync_err(serr[0])
  );

  rom_bus_controller #(.ROM_BANK(4'h3)) u3 (
    .clock(clock), .reset(reset), .sync(sync), .data_in(data_in),
    .data_out(dout[1]), .data_oe(doe[1]), .mem_rd(mrd[1]), .mem_addr(maddr[1]),
    .mem_rdata(mrdata[1]), .phase(ph[1]), .locked(lck[1]), .selected(sel[1]),
    .sync_err(serr[1])
  );

  function automatic logic [3:0] bank_of(input int k);
    return (k == 0) ? 4'h0 : 4'h3;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [3:0] bank, input logic [7:0] addr);
    if (bank == 4'h0 && addr == 8'hA5) return 8'hD4;
    return (addr ^ {bank, ~bank}) + 8'h13;
  endfunction

  initial begin
    mrdata[0] = 8'h00;
    mrdata[1] = 8'h00;
  end

  // Synchronous program memories, data valid one clock after the read strobe.
  always @(posedge clock) if (mrd[0]) mrdata[0] <= mem_byte(4'h0, maddr[0]);
  always @(posedge clock) if (mrd[1]) mrdata[1] <= mem_byte(4'h3, maddr[1]);

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s u%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic [3:0] d);
    @(negedge clock);
    sync = s;
    data_in = d;
    #1;
  endtask

  function automatic logic [7:0] head(input int k);
    if (k == 0) return (q0.size() > 0) ? q0[0] : 8'hxx;
    return (q1.size() > 0) ? q1[0] : 8'hxx;
  endfunction

  task automatic pop(input int k);
    if (k == 0 && q0.size() > 0) void'(q0.pop_front());
    if (k == 1 && q1.size() > 0) void'(q1.pop_front());
  endtask

  task automatic run_frame(input logic [11:0] a, input logic x3_sync, input int last_p);
    for (int p = 0; p <= last_p; p++) begin
      logic [3:0] d;
      d = (p == 0) ? a[3:0] : (p == 1) ? a[7:4] : (p == 2) ? a[11:8] : 4'h0;
      cyc((p == 7) ? x3_sync : 1'b0, d);
      for (int k = 0; k < 2; k++) begin
        logic hit;
        logic [7:0] e;
        hit = (a[11:8] == bank_of(k));
        chk("phase", k, 32'(ph[k]), 32'(p));
        chk("sync_err", k, 32'(serr[k]), 32'd0);
        if (p == 2) begin
          chk("mem_rd", k, 32'(mrd[k]), 32'(hit));
          if (hit) begin
            chk("mem_addr", k, 32'(maddr[k]), 32'(a[7:0]));
            if (k == 0) q0.push_back(mem_byte(bank_of(k), a[7:0]));
            else q1.push_back(mem_byte(bank_of(k), a[7:0]));
          end
        end
        chk("selected", k, 32'(sel[k]), (p >= 3) ? 32'(hit) : 32'd0);
        if ((p == 3 || p == 4) && hit) begin
          e = head(k);
          chk("data_oe", k, 32'(doe[k]), 32'd1);
          chk("data_out", k, 32'(dout[k]), (p == 3) ? 32'(e[7:4]) : 32'(e[3:0]));
          if (p == 4) pop(k);
        end else begin
          chk("data_oe", k, 32'(doe[k]), 32'd0);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] e;

    // Reset state.
    cyc(1'b0, 4'h0);
    cyc(1'b1, 4'hF);
    for (int k = 0; k < 2; k++) begin
      chk("rst_locked", k, 32'(lck[k]), 32'd0);
      chk("rst_phase", k, 32'(ph[k]), 32'd7);
      chk("rst_oe", k, 32'(doe[k]), 32'd0);
      chk("rst_out", k, 32'(dout[k]), 32'd0);
      chk("rst_sel", k, 32'(sel[k]), 32'd0);
      chk("rst_err", k, 32'(serr[k]), 32'd0);
    end

    // Sync on the clock that reset deasserts locks the controller.
    @(negedge clock);
    reset = 1'b1;
    sync = 1'b1;
    data_in = 4'h0;
    #1;
    for (int k = 0; k < 2; k++) chk("prelock", k, 32'(lck[k]), 32'd0);
    cyc(1'b0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      chk("lock", k, 32'(lck[k]), 32'd1);
      chk("lock_phase", k, 32'(ph[k]), 32'd7);
      chk("lock_err", k, 32'(serr[k]), 32'd0);
    end

    // Fetch 0x0A5 from bank 0 (returns D then 4), then a miss on bank 2.
    run_frame(12'h0A5, 1'b1, 7);
    run_frame(12'h2A5, 1'b1, 7);

    // Back-to-back frames on bank 3.
    run_frame(12'h300, 1'b1, 7);
    run_frame(12'h301, 1'b1, 7);
    run_frame(12'h3FF, 1'b1, 7);

    // Early sync during M1 of a selected fetch.
    run_frame(12'h312, 1'b1, 2);
    cyc(1'b1, 4'h0);
    e = head(1);
    chk("es_m1_phase", 1, 32'(ph[1]), 32'd3);
    chk("es_m1_oe", 1, 32'(doe[1]), 32'd1);
    chk("es_m1_out", 1, 32'(dout[1]), 32'(e[7:4]));
    cyc(1'b0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      chk("es_err", k, 32'(serr[k]), 32'd1);
      chk("es_phase", k, 32'(ph[k]), 32'd7);
      chk("es_oe", k, 32'(doe[k]), 32'd0);
      chk("es_sel", k, 32'(sel[k]), 32'd0);
      chk("es_locked", k, 32'(lck[k]), 32'd1);
    end
    pop(1);
    run_frame(12'h3C7, 1'b1, 7);

    // Missing sync at X3, ignored bus activity, then relock.
    run_frame(12'h05E, 1'b0, 7);
    cyc(1'b0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      chk("ms_err", k, 32'(serr[k]), 32'd1);
      chk("ms_locked", k, 32'(lck[k]), 32'd0);
      chk("ms_sel", k, 32'(sel[k]), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, (i[0]) ? 4'h3 : 4'h0);
      for (int k = 0; k < 2; k++) begin
        chk("unl_locked", k, 32'(lck[k]), 32'd0);
        chk("unl_rd", k, 32'(mrd[k]), 32'd0);
        chk("unl_oe", k, 32'(doe[k]), 32'd0);
        chk("unl_err", k, 32'(serr[k]), 32'd0);
      end
    end
    cyc(1'b1, 4'h0);
    cyc(1'b0, 4'h0);
    for (int k = 0; k < 2; k++) chk("relock", k, 32'(lck[k]), 32'd1);
    run_frame(12'h37E, 1'b1, 7);
    run_frame(12'h0A5, 1'b1, 7);

    // Asynchronous reset during M2 of a selected fetch.
    run_frame(12'h3AB, 1'b1, 3);
    cyc(1'b0, 4'h0);
    e = head(1);
    chk("ar_m2_oe", 1, 32'(doe[1]), 32'd1);
    chk("ar_m2_out", 1, 32'(dout[1]), 32'(e[3:0]));
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("ar_oe", k, 32'(doe[k]), 32'd0);
      chk("ar_out", k, 32'(dout[k]), 32'd0);
      chk("ar_locked", k, 32'(lck[k]), 32'd0);
      chk("ar_phase", k, 32'(ph[k]), 32'd7);
      chk("ar_sel", k, 32'(sel[k]), 32'd0);
      chk("ar_rd", k, 32'(mrd[k]), 32'd0);
      chk("ar_err", k, 32'(serr[k]), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_bus_controller.md
Name: rom_bus_controller

Overview:
- Memory-side sequencer for the CPU's 4-bit multiplexed instruction bus.
- Tracks the 8-phase bus cycle framed by `sync` and assembles the 12-bit fetch address from three nibbles.
- Reads one byte from a 256-byte synchronous program memory and returns it as OPR then OPA.
- One instance per 256-byte bank, selected by the high address nibble; drives a separate data_out/data_oe pair that the top level merges onto the shared tri-state bus.

Parameters:
- ROM_BANK, 4'h0, value of address bits [11:8] that selects this instance.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- sync  input  1  from CPU; high for one clock marking phase X3; next clock is A1.
- data_in  input  4  sampled value of the shared data bus.
- data_out  output  4  nibble to drive onto the bus.
- data_oe  output  1  bus drive enable for data_out.
- mem_rd  output  1  one-cycle read strobe to program memory.
- mem_addr  output  8  byte address within this bank.
- mem_rdata  input  8  memory read data; valid exactly one clock after mem_rd.
- phase  output  3  current phase: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
- locked  output  1  high while the controller is tracking bus phases.
- selected  output  1  high from M1 through X3 when the current cycle's bank equals ROM_BANK.
- sync_err  output  1  one-clock pulse on a framing violation.

Behaviour:
- Reset (reset==0, asynchronous):
  - locked=0, phase=7, selected=0, mem_rd=0, data_oe=0, data_out=0, sync_err=0.
  - Address nibble registers and byte latch are cleared to 0.
- Unlocked state:
  - Ignore data_in.
  - On a clock with sync=1: set locked=1, phase=7. The next clock is A1.
- Locked operation: phase advances by 1 each clock, 7 wraps to 0.
- Sync checking while locked:
  - sync=1 with phase!=7: pulse sync_err, force phase=7, so the next clock is A1. Any in-flight fetch is abandoned: selected=0, no drive.
  - phase==7 with sync=0: pulse sync_err, set locked=0, selected=0.
- Address capture:
  - A1: capture data_in into addr[3:0].
  - A2: capture data_in into addr[7:4].
- A3 (combinational):
  - mem_addr={addr[7:4],addr[3:0]}.
  - mem_rd=1 only if data_in==ROM_BANK; otherwise mem_rd=0.
  - mem_addr may hold any value when mem_rd=0.
- selected register:
  - At the A3→M1 edge, loaded with (data_in==ROM_BANK).
  - Cleared at the X3→A1 edge.
- M1:
  - If selected: data_out=mem_rdata[7:4], data_oe=1.
  - At the end of M1, latch mem_rdata into the byte register.
- M2:
  - If selected: data_out=byte[3:0] (latched), data_oe=1.
- All other phases, or selected=0: data_oe=0, data_out=0.
- data_oe never asserts in two consecutive cycle frames without an intervening A1–A3 address sequence.
- mem_rdata is ignored outside M1.
- Reset mid-cycle aborts immediately: data_oe drops asynchronously and the controller returns to unlocked.
- sync asserted on the very clock reset deasserts is honoured (locks).
- Latency: one memory read per selected cycle. First nibble on the bus the clock after A3; second nibble one clock later.

Test Plan:
- Lock and fetch, ROM_BANK=0:
  - Stimulus: reset, sync pulse, then drive nibbles 5,A,0 in A1–A3; memory returns 8'hD4 at M1.
  - Required: mem_rd=1 with mem_addr=8'hA5 in A3; data_out=D with data_oe=1 in M1; data_out=4 with data_oe=1 in M2; data_oe=0 in X1–X3.
- Bank miss, ROM_BANK=3:
  - Stimulus: A3 nibble=2.
  - Required: mem_rd=0, selected=0, data_oe=0 for the whole cycle.
- Back-to-back cycles:
  - Stimulus: three consecutive frames at addresses 0x300, 0x301, 0x3FF with ROM_BANK=3.
  - Required: mem_addr 00, 01, FF, each with correct OPR/OPA; no sync_err.
- Early sync:
  - Stimulus: sync=1 during M1 of a selected cycle.
  - Required: sync_err pulse; data_oe=0 from the next clock; the next clock reports phase=7 and the following clock is A1; a normal fetch follows.
- Missing sync:
  - Stimulus: sync held 0 at X3.
  - Required: sync_err pulse, locked=0; bus activity ignored until the next sync; relock then fetches correctly.
- Async reset during M2:
  - Stimulus: assert reset during M2.
  - Required: data_oe=0 and locked=0 immediately, before the next clock edge; all outputs at their reset values.
